// File: rtl/dmem_block_responder.sv
// Fixed-latency block memory behind the dcache miss path: one refill or writeback at a time,
// each completed with a single-cycle memReadReady / memWriteDone pulse.
module dmem_block_responder #(
    parameter int ADDR_W     = 8,
    parameter int BLOCK_BITS = 128,
    parameter int READ_LAT   = 4,   // 1..15
    parameter int WRITE_LAT  = 4    // 1..15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memRen,
    input  logic                  memWen,
    input  logic [ADDR_W-1:0]     BlockAddr,
    input  logic [BLOCK_BITS-1:0] memDin,
    output logic                  memReadReady,
    output logic                  memWriteDone,
    output logic [BLOCK_BITS-1:0] memDout
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] RD_LAT_C = 4'(READ_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WRITE_LAT);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;
    logic [ADDR_W-1:0]       r_addr;
    logic [ADDR_W-1:0]       w_addr_next;
    logic [BLOCK_BITS-1:0]   r_data;
    logic [BLOCK_BITS-1:0]   w_data_next;
    logic                    r_read_ready;
    logic                    r_write_done;
    logic [BLOCK_BITS-1:0]   r_dout;
    logic                    w_load_rd;
    logic                    w_commit_wr;

    logic [BLOCK_BITS-1:0]   r_mem [0:DEPTH-1];

    // Writeback takes priority over refill when both are requested.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        case (r_state)
            IDLE: begin
                if (memWen) begin
                    w_state_next = WR_WAIT;
                    w_cnt_next   = WR_LAT_C;
                    w_addr_next  = BlockAddr;
                    w_data_next  = memDin;
                end else if (memRen) begin
                    w_state_next = RD_WAIT;
                    w_cnt_next   = RD_LAT_C;
                    w_addr_next  = BlockAddr;
                end
            end
            RD_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = RD_DONE;
                end
            end
            WR_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = WR_DONE;
                end
            end
            RD_DONE: w_state_next = IDLE;
            WR_DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign w_load_rd   = (r_state == RD_WAIT) && (r_cnt == 4'd1);
    assign w_commit_wr = (r_state == WR_WAIT) && (r_cnt == 4'd1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= '0;
            r_data       <= '0;
            r_read_ready <= 1'b0;
            r_write_done <= 1'b0;
            r_dout       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_addr       <= w_addr_next;
            r_data       <= w_data_next;
            r_read_ready <= (w_state_next == RD_DONE);
            r_write_done <= (w_state_next == WR_DONE);
            if (w_load_rd) begin
                r_dout <= r_mem[r_addr];
            end
        end
    end

    // Array has no reset; a reset during WR_WAIT forces IDLE, so nothing is committed.
    always_ff @(posedge clock) begin
        if (w_commit_wr) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign memReadReady = r_read_ready;
    assign memWriteDone = r_write_done;
    assign memDout      = r_dout;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Directed bench for dmem_block_responder: a vector table of block reads/writes on two
// latency configurations plus hand sequences for simultaneous requests and mid-write reset.
module tb_dmem_block_responder;

    typedef struct {
        bit           sel;    // 0: READ_LAT=4/WRITE_LAT=4, 1: READ_LAT=1/WRITE_LAT=7
        bit           wr;
        logic [7:0]   addr;
        logic [127:0] data;   // write data, or expected memDout for a read
        int           lat;
        int           mode;   // 0: drop on pulse, 1: hold one cycle past pulse, 2: abandon after T0
    } vec_t;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
    localparam logic [127:0] D3 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] D4 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE;
    localparam logic [127:0] D5 = 128'h00000000_00000000_00000000_00000001;
    localparam logic [127:0] D6 = 128'h00000010_11111111_22222222_33333333;
    localparam logic [127:0] D7 = 128'h77770000_77770000_77770000_77770000;
    localparam logic [127:0] DA = {16{8'hAA}};
    localparam int NVEC = 13;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ren0 = 1'b0, wen0 = 1'b0, ren1 = 1'b0, wen1 = 1'b0;
    logic [7:0]   addr0 = '0, addr1 = '0;
    logic [127:0] din0 = '0, din1 = '0;
    logic         rr0, wd0, rr1, wd1;
    logic [127:0] dout0, dout1;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t vecs [NVEC];

    always #5 clock = ~clock;

    dmem_block_responder #(
        .ADDR_W(8), .BLOCK_BITS(128), .READ_LAT(4), .WRITE_LAT(4)
    ) u_dut0 (
        .clock(clock), .reset(reset), .memRen(ren0), .memWen(wen0),
        .BlockAddr(addr0), .memDin(din0),
        .memReadReady(rr0), .memWriteDone(wd0), .memDout(dout0)
    );

    dmem_block_responder #(
        .ADDR_W(8), .BLOCK_BITS(128), .READ_LAT(1), .WRITE_LAT(7)
    ) u_dut1 (
        .clock(clock), .reset(reset), .memRen(ren1), .memWen(wen1),
        .BlockAddr(addr1), .memDin(din1),
        .memReadReady(rr1), .memWriteDone(wd1), .memDout(dout1)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [7:0] a, input logic [127:0] d);
        if (sel) begin
            ren1 = r; wen1 = w; addr1 = a; din1 = d;
        end else begin
            ren0 = r; wen0 = w; addr0 = a; din0 = d;
        end
    endtask

    function automatic logic get_pulse(input bit sel, input bit wr);
        if (wr) return sel ? wd1 : wd0;
        return sel ? rr1 : rr0;
    endfunction

    function automatic logic [127:0] get_dout(input bit sel);
        return sel ? dout1 : dout0;
    endfunction

    // Issues one request, scrambles address/data after acceptance, and measures latency from T0.
    task automatic run_txn(input vec_t v, input int idx);
        int           first;
        int           npulse;
        int           nother;
        bit           stable;
        logic [127:0] held;
        logic         cr;
        logic         cw;
        first  = -1;
        npulse = 0;
        nother = 0;
        stable = 1'b1;
        held   = '0;
        cr     = !v.wr;
        cw     = v.wr;
        drive(v.sel, cr, cw, v.addr, v.data);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (get_pulse(v.sel, v.wr)) begin
                npulse++;
                if (first < 0) begin
                    first = n;
                    held  = get_dout(v.sel);
                end
            end
            if (get_pulse(v.sel, !v.wr)) nother++;
            if (first > 0 && n > first && get_dout(v.sel) !== held) stable = 1'b0;
            if (n == 1 && v.mode == 2) begin cr = 1'b0; cw = 1'b0; end
            if (first == n && v.mode == 0) begin cr = 1'b0; cw = 1'b0; end
            if (first > 0 && n == first + 1 && v.mode == 1) begin cr = 1'b0; cw = 1'b0; end
            drive(v.sel, cr, cw, v.addr ^ 8'h03, ~v.data);
            if (first > 0 && n >= first + 5) break;
        end
        if (first < 0) begin
            chk_int($sformatf("v%0d timeout", idx), 0, 1);
        end else begin
            chk_int($sformatf("v%0d latency", idx), first - 1, v.lat);
            chk_int($sformatf("v%0d pulse_count", idx), npulse, 1);
            chk_int($sformatf("v%0d other_pulse", idx), nother, 0);
            chk_int($sformatf("v%0d dout_stable", idx), int'(stable), 1);
            if (!v.wr) chk($sformatf("v%0d dout", idx), held, v.data);
        end
        $display("txn %0d: dut%0d %s addr=%h lat=%0d dout=%h", idx, v.sel,
                 v.wr ? "WR" : "RD", v.addr, first - 1, held);
    endtask

    initial begin
        int           wf;
        int           rf;
        int           both;
        int           extra;
        logic [127:0] rdd;
        vec_t         rv;

        vecs[0]  = '{1'b0, 1'b1, 8'h05, D1, 4, 0};
        vecs[1]  = '{1'b0, 1'b0, 8'h05, D1, 4, 0};
        vecs[2]  = '{1'b0, 1'b1, 8'h06, D2, 4, 0};
        vecs[3]  = '{1'b0, 1'b0, 8'h05, D1, 4, 1};
        vecs[4]  = '{1'b0, 1'b0, 8'h06, D2, 4, 2};
        vecs[5]  = '{1'b1, 1'b1, 8'h33, D3, 7, 0};
        vecs[6]  = '{1'b1, 1'b0, 8'h33, D3, 1, 0};
        vecs[7]  = '{1'b1, 1'b0, 8'h33, D3, 1, 2};
        vecs[8]  = '{1'b0, 1'b1, 8'hFF, D4, 4, 0};
        vecs[9]  = '{1'b0, 1'b0, 8'hFF, D4, 4, 1};
        vecs[10] = '{1'b0, 1'b1, 8'h00, D5, 4, 2};
        vecs[11] = '{1'b0, 1'b0, 8'h00, D5, 4, 0};
        vecs[12] = '{1'b0, 1'b1, 8'h20, D7, 4, 0};

        reset = 1'b0;
        tick();
        tick();
        chk("reset rr0", {127'b0, rr0}, '0);
        chk("reset wd0", {127'b0, wd0}, '0);
        chk("reset dout0", dout0, '0);
        chk("reset rr1", {127'b0, rr1}, '0);
        chk("reset wd1", {127'b0, wd1}, '0);
        chk("reset dout1", dout1, '0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i], i);
        end

        // Both requests together: write served first, read accepted two edges after WR_DONE.
        wf = -1; rf = -1; both = 0; rdd = '0;
        drive(1'b0, 1'b1, 1'b1, 8'h10, D6);
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (wd0 && rr0) both++;
            if (wd0 && wf < 0) begin
                wf = n;
                drive(1'b0, 1'b1, 1'b0, 8'h10, D6);
            end
            if (rr0 && rf < 0) begin
                rf  = n;
                rdd = dout0;
                drive(1'b0, 1'b0, 1'b0, 8'h10, D6);
            end
            if (rf > 0 && n >= rf + 2) break;
        end
        chk_int("simul wr_latency", wf - 1, 4);
        chk_int("simul rd_latency", rf - 1, 10);
        chk("simul dout", rdd, D6);
        chk_int("simul both_pulses", both, 0);
        $display("txn simul: wr_done at T0+%0d, rd_ready at T0+%0d, dout=%h", wf - 1, rf - 1, rdd);

        // Reset during WR_WAIT must drop the pending write.
        extra = 0;
        drive(1'b0, 1'b0, 1'b1, 8'h20, DA);
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("midrst rr0", {127'b0, rr0}, '0);
        chk("midrst wd0", {127'b0, wd0}, '0);
        chk("midrst dout0", dout0, '0);
        drive(1'b0, 1'b0, 1'b0, 8'h20, DA);
        for (int n = 0; n < 3; n++) begin
            tick();
            if (wd0) extra++;
        end
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (wd0) extra++;
        end
        chk_int("midrst no_done", extra, 0);
        $display("txn midrst: write to 20 aborted by reset, stray done pulses=%0d", extra);
        rv = '{1'b0, 1'b0, 8'h20, D7, 4, 0};
        run_txn(rv, NVEC);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
